aes256_cipher_core: RTL and testbench
=====================================

# aes256_cipher_core

Iterative AES-256 encryption datapath that consumes the 60-word expanded key schedule produced by the key-expansion stage and encrypts one 128-bit block, one round per clock. The block sits directly downstream of key expansion. It uses a valid/ready handshake on both the plaintext input and the ciphertext output.

## Interface
Parameters: none (AES-256 fixed: Nk=8, Nr=14).

Ports:
- clk  in  1  — single clock, rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- w  in  [0:1919]  — expanded key schedule, words w0..w59.
  - Round key r occupies w[128*r : 128*r+127].
- din  in  [0:127]  — plaintext in FIPS-197 byte order.
  - din[0:7] is byte 0.
  - State is column-major: byte k maps to row k%4, column k/4.
- in_valid  in  1  — din and w are valid.
- in_ready  out  1  — core idle and able to accept a block.
- dout  out  [0:127]  — ciphertext, same byte order as din.
- out_valid  out  1  — dout holds a finished ciphertext.
- out_ready  in  1  — downstream accepts dout.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: round counter rnd runs 1..14.
  - DONE: out_valid=1.
- Accept: the handshake is in_valid && in_ready at a rising edge.
  - state ← din ^ w[0:127].
  - rnd ← 1; FSM → RUN.
- RUN, each cycle, in order:
  - SubBytes: 16 parallel S-box lookups.
  - ShiftRows: row i rotated left by i bytes.
  - MixColumns over GF(2^8), reduction polynomial 0x11B. Skipped when rnd==14.
  - AddRoundKey with round key rnd.
  - Then rnd ← rnd+1.
  - At rnd==14 the result is loaded into dout and FSM → DONE.
- DONE:
  - dout and out_valid are held stable until out_valid && out_ready at a rising edge.
  - Then out_valid ← 0 and FSM → IDLE.
  - dout keeps its last value after the output handshake.
- in_valid in RUN/DONE is ignored (in_ready=0). No overlap of consecutive blocks.
- rnd is 4 bits; values 0 and 15 are never reached. Any illegal state recovers to IDLE.
- Reset (asynchronous, any state, including mid-round):
  - FSM=IDLE, rnd=0, internal state=0.
  - dout=0, out_valid=0, in_ready=1.
  - The in-flight block is discarded.

## Timing
- Latency: accept edge E → out_valid high after edge E+14.
- Minimum cycle between blocks is 16 clocks with out_ready tied high:
  - output handshake at E+15;
  - earliest next accept at E+16.
- in_ready is a registered-state decode (state==IDLE) with no combinational path from in_valid. The same holds for out_valid.
- out_valid deassertion is visible after the handshake edge. in_ready rises in the same cycle.
- Reset deassertion: in_ready=1 is seen in the first cycle. The first accept may happen on the first rising edge with rst_n high.

## Configuration
- Macro AES256_CIPHER_KEY_LATCH_EN controls key capture.
- Defined: w is captured into an internal 1920-bit register on the accept edge. All rounds use the captured copy, so upstream may change key or w immediately after accept.
- Undefined: no key register. Upstream must hold w stable from the accept edge until the out_valid edge. Changing w in that window yields undefined ciphertext.
- Handshake timing and latency are identical in both builds.

## Test plan
- FIPS-197 C.3 check:
  - Stimulus: w from key 000102…1e1f, din=00112233445566778899aabbccddeeff, out_ready=1.
  - Required: dout=8ea2b7ca516745bfeafc49904b496089; out_valid first high 14 cycles after accept.
- SP800-38A ECB-AES256 check:
  - Stimulus: key 603deb10…0914dff4, din=6bc1bee22e409f96e93d7e117393172a.
  - Required: dout=f3eed1bdb5d2a03c064b5a7e3db181f8.
- Back-pressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, with in_valid held high and new din.
  - Required: dout/out_valid stable, in_ready=0, no second accept; after out_ready=1, next accept occurs exactly 1 cycle later.
- Back-to-back:
  - Stimulus: two C.3 blocks, in_valid and out_ready held high.
  - Required: accepts 16 cycles apart; both outputs 8ea2b7ca…4b496089.
- Reset mid-operation:
  - Stimulus: rst_n low at round 7.
  - Required: immediately out_valid=0, dout=0, in_ready=1; the next block encrypts correctly.
- With AES256_CIPHER_KEY_LATCH_EN:
  - Stimulus: corrupt w to all-zeros one cycle after accept.
  - Required: dout still equals the expected ciphertext.

Source files
------------

// File: rtl/aes256_cipher_core.sv
// aes256_cipher_core -- iterative AES-256 encryption, one round per clock.
//
// Takes a 60-word expanded key schedule and one 128-bit plaintext block and
// produces the ciphertext 14 clocks after the accept edge. Both sides use a
// valid/ready handshake, and only one block is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   w          key schedule w0..w59, round key r = w[128*r +: 128]
//   din        plaintext, byte 0 = din[0:7], column-major state
//   in_valid   din/w valid
//   in_ready   core idle, will accept on in_valid
//   dout       ciphertext, same byte order as din
//   out_valid  dout holds a finished block
//   out_ready  downstream takes dout
//
// Build option:
//   AES256_CIPHER_KEY_LATCH_EN  defined: w is captured on the accept edge, so
//                               upstream may change w right after accept.
//                               undefined: w must stay stable until out_valid.

// One S-box lane: a 256-entry byte table, row-major (entry 0 first).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bits [2047-8a -: 8], i.e. base 8*(255-a) = {~a, 3'b000}.
  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes256_cipher_core (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:1919] w,
  input  logic [0:127]  din,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [0:127]  dout,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam int NUM_LANES = 16;
  localparam int NR        = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [3:0]    rnd_q;
  logic [0:127]  st_q;
  logic [0:1919] key_src;
  logic [0:127]  rk;
  logic [0:127]  rnd_out;
  logic          last_rnd;
  logic          rnd_bad;

  logic [NUM_LANES-1:0][7:0] sb;   // after SubBytes, indexed by byte
  logic [NUM_LANES-1:0][7:0] sr;   // after ShiftRows
  logic [NUM_LANES-1:0][7:0] mc;   // after MixColumns

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign last_rnd  = (rnd_q == 4'(NR));
  assign rnd_bad   = (rnd_q == 4'd0) || (rnd_q == 4'd15);

  // Round 0 always uses w directly at the accept edge, so only rounds 1..14
  // need the (optionally latched) copy.
`ifdef AES256_CIPHER_KEY_LATCH_EN
  logic [0:1919] key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  key_q <= '0;
    else if (in_valid && in_ready) key_q <= w;
  end

  assign key_src = key_q;
`else
  assign key_src = w;
`endif

  always_comb begin
    rk = '0;
    for (int r = 1; r <= NR; r++)
      if (rnd_q == 4'(r)) rk = key_src[128*r +: 128];
  end

  // Byte k lives at row k%4, column k/4. ShiftRows moves row r left by r, so
  // output (r,c) takes input (r,(c+r)%4).
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    aes_sbox u_sbox (
      .a (st_q[8*k +: 8]),
      .y (sb[k])
    );

    assign sr[k] = sb[4*(((k/4) + (k%4)) % 4) + (k%4)];
    assign rnd_out[8*k +: 8] = (last_rnd ? sr[k] : mc[k]) ^ rk[8*k +: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c+0];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];

    assign mc[4*c+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (in_valid) fsm_d = RUN;
      RUN: begin
        if (rnd_bad)       fsm_d = IDLE;
        else if (last_rnd) fsm_d = DONE;
      end
      DONE: if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      rnd_q <= '0;
      dout  <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            st_q  <= din ^ w[0:127];
            rnd_q <= 4'd1;
          end
        end
        RUN: begin
          st_q <= rnd_out;
          if (last_rnd) begin
            dout  <= rnd_out;
            rnd_q <= '0;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes256_cipher_core.sv
// Scoreboard bench for aes256_cipher_core: an accept monitor pushes the
// expected ciphertext (known-answer constant or reference model) and an
// output monitor pops and compares it, also checking latency, hold
// stability under back-pressure and handshake spacing.
module tb_aes256_cipher_core;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [0:1919] w;
  logic [0:127]  din;
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  dout;
  logic          out_valid;
  logic          out_ready;

  aes256_cipher_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w         (w),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  localparam logic [0:255] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [0:127] SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [0:127] SP_CT  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  typedef struct {
    logic [0:127] exp;
    int           edge_n;
  } exp_t;

  exp_t         sb_q[$];
  int           n_chk = 0, n_pass = 0;
  int           edge_cnt = 0, n_acc = 0;
  int           last_hs = -100, last_acc = -100;
  int           gap_mode = 0;     // 1: accept one edge after handshake, 2: also 16 after previous accept
  logic         use_kat = 1'b0;
  logic [0:127] kat_ct;
  logic [7:0]   sbox_t[256];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  // ---------------- reference model (FIPS-197 from first principles) -------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic void init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  function automatic logic [0:1919] expand(logic [0:255] key);
    logic [31:0]   wd[60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] o;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) wd[i] = key[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = wd[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      wd[i] = wd[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) o[32*i +: 32] = wd[i];
    return o;
  endfunction

  function automatic logic [0:127] encrypt(logic [0:1919] ks, logic [0:127] pt);
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[8*(4*c+r) +: 8] ^ ks[8*(4*c+r) +: 8];
    for (int rd = 1; rd <= 14; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = sbox_t[s[r][c]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = s[r][(c+r)%4];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd < 14)
            s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^
                      t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] ^= ks[128*rd + 8*(4*c+r) +: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = s[r][c];
    return o;
  endfunction

  // ---------------- monitors ------------------------------------------------
  always @(posedge clk) edge_cnt++;

  // Accept side: the handshake completes on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_t e;
      e.exp    = use_kat ? kat_ct : encrypt(w, din);
      e.edge_n = edge_cnt + 1;
      if (gap_mode != 0) begin
        chk("accept_after_handshake", e.edge_n, last_hs + 1);
        if (gap_mode == 2) chk("accept_spacing", e.edge_n, last_acc + 16);
        gap_mode = 0;
      end
      last_acc = e.edge_n;
      n_acc++;
      sb_q.push_back(e);
    end
  end

  logic         ov_prev = 1'b0;
  logic         hold = 1'b0;
  logic [0:127] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      ov_prev = 1'b0;
      hold    = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_out_valid", out_valid, 1);
        chk("hold_dout", dout, held);
      end
      if (out_valid && !ov_prev) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: dout %h with no accepted block", dout);
        end else begin
          chk("latency", edge_cnt, sb_q[0].edge_n + 14);
        end
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() != 0) begin
          chk("ciphertext", dout, sb_q[0].exp);
          void'(sb_q.pop_front());
        end
        last_hs = edge_cnt + 1;
      end
      hold    = out_valid && !out_ready;
      held    = dout;
      ov_prev = out_valid;
    end
  end

  // ---------------- driver --------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(int n);
    int k;
    k = 0;
    while (n_acc < n && k < 200) begin tick(); k++; end
    if (n_acc < n) begin
      n_chk++;
      $display("FAIL accept_timeout: accepts %0d want %0d", n_acc, n);
    end
  endtask

  task automatic drain(bit rand_ready);
    int k;
    k = 0;
    while (!(sb_q.size() == 0 && in_ready) && k < 300) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    out_ready = 1'b1;
    if (!(sb_q.size() == 0 && in_ready)) begin
      n_chk++;
      $display("FAIL drain_timeout: pending %0d in_ready %0b", sb_q.size(), in_ready);
    end
  endtask

  task automatic rand_block();
    logic [0:255] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    w   = expand(k);
    din = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin : drv
    int na;
    int k;
    init_sbox();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w         = '0;
    din       = '0;
    na        = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dout", dout, 0);

    // C.3 twice back to back, first accept on the first edge out of reset
    w = expand(C3_KEY); din = C3_PT; kat_ct = C3_CT; use_kat = 1'b1;
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    na += 1; wait_acc(na);
    gap_mode = 2;
    na += 1; wait_acc(na);
    in_valid = 1'b0;
    use_kat  = 1'b0;
    drain(1'b0);

    // SP800-38A ECB-AES256 block 1
    w = expand(SP_KEY); din = SP_PT; kat_ct = SP_CT; use_kat = 1'b1;
    in_valid = 1'b1;
    na += 1; wait_acc(na);
    in_valid = 1'b0;
    use_kat  = 1'b0;
    drain(1'b0);

    // Back-pressure with a new block waiting
    out_ready = 1'b0;
    rand_block();
    in_valid = 1'b1;
    na += 1; wait_acc(na);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin tick(); k++; end
    chk("bp_out_valid_seen", out_valid, 1);
    din      = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    repeat (10) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_no_accept", n_acc, na);
    gap_mode  = 1;
    out_ready = 1'b1;
    na += 1; wait_acc(na);
    in_valid = 1'b0;
    drain(1'b0);

    // Reset while round 7 is in progress
    rand_block();
    in_valid = 1'b1;
    na += 1; wait_acc(na);
    in_valid = 1'b0;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rand_block();
    in_valid = 1'b1;
    na += 1; wait_acc(na);
    in_valid = 1'b0;
    drain(1'b0);

    // Random blocks with random output back-pressure
    for (int i = 0; i < 5; i++) begin
      rand_block();
      in_valid = 1'b1;
      na += 1; wait_acc(na);
      in_valid = 1'b0;
      drain(1'b1);
    end

`ifdef AES256_CIPHER_KEY_LATCH_EN
    // Key schedule trashed one cycle after accept
    w = expand(C3_KEY); din = C3_PT; kat_ct = C3_CT; use_kat = 1'b1;
    in_valid = 1'b1;
    na += 1; wait_acc(na);
    in_valid = 1'b0;
    use_kat  = 1'b0;
    tick();
    w   = '0;
    din = '0;
    drain(1'b0);
`endif

    repeat (3) tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("total_accepts", n_acc, na);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
